// File: rtl/pcie_dll_fc_credit_gate_pkg.sv
// Shared types and constants for the transmit-side DLL flow-control credit gate.
// Scale encodings, field widths, per-scale outstanding limits, FC DLLP header layout.
package pcie_dll_fc_credit_gate_pkg;

    localparam int NUM_FC_TYPES    = 3;
    localparam int HDR_FIELD_BITS  = 12;
    localparam int DATA_FIELD_BITS = 16;
    localparam int REQ_DATA_BITS   = 10;
    localparam int HDR_FC_BITS     = 8;
    localparam int DATA_FC_BITS    = 12;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_type_e;

    typedef enum logic [1:0] {
        DLLP_INITFC1  = 2'd0,
        DLLP_INITFC2  = 2'd1,
        DLLP_UPDATEFC = 2'd2,
        DLLP_FC_RSVD  = 2'd3
    } dllp_fc_kind_e;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_INIT1 = 2'd1,
        FC_INIT2 = 2'd2,
        FC_READY = 2'd3
    } fc_state_e;

    localparam logic [1:0] SCALE_1X_A = 2'b00;
    localparam logic [1:0] SCALE_1X_B = 2'b01;
    localparam logic [1:0] SCALE_4X   = 2'b10;
    localparam logic [1:0] SCALE_16X  = 2'b11;

    localparam int HDR_MAX_1X   = 127;
    localparam int HDR_MAX_4X   = 508;
    localparam int HDR_MAX_16X  = 2032;
    localparam int DATA_MAX_1X  = 2047;
    localparam int DATA_MAX_4X  = 8188;
    localparam int DATA_MAX_16X = 32752;

    typedef struct packed {
        dllp_fc_kind_e           kind;
        logic [1:0]              fc_type;
        logic [1:0]              hdr_scale;
        logic [1:0]              data_scale;
        logic [HDR_FC_BITS-1:0]  hdr_fc;
        logic [DATA_FC_BITS-1:0] data_fc;
    } fcp_hdr_t;

    // Left-shift applied to a raw FC field for a given scale encoding.
    function automatic logic [2:0] scale_shift(input logic [1:0] enc);
        case (enc)
            SCALE_4X:  return 3'd2;
            SCALE_16X: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/pcie_fc_credit_slot.sv
// One flow-control counter (hdr or data of one FC type): credit limit, credits consumed,
// infinite flag and recorded scale, with init/update/consume and the FCPE bound check.
module pcie_fc_credit_slot
    import pcie_dll_fc_credit_gate_pkg::*;
#(
    parameter int W       = 12,
    parameter int RAW_W   = 8,
    parameter int MAX_1X  = 127,
    parameter int MAX_4X  = 508,
    parameter int MAX_16X = 2032
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_init,
    input  logic             i_upd,
    input  logic [1:0]       i_scale,
    input  logic [RAW_W-1:0] i_raw,
    input  logic             i_cons,
    input  logic [W-1:0]     i_req,
    output logic             o_ok,
    output logic             o_inf,
    output logic             o_fcpe
);

    localparam logic [W-1:0] M1   = W'(MAX_1X);
    localparam logic [W-1:0] M4   = W'(MAX_4X);
    localparam logic [W-1:0] M16  = W'(MAX_16X);
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] r_cl;
    logic [W-1:0] r_cc;
    logic         r_inf;
    logic [2:0]   r_shift;

    logic [2:0]   w_shift;
    logic [W-1:0] w_scaled;
    logic [W-1:0] w_max;
    logic [W-1:0] w_outstanding;
    logic [W-1:0] w_room;
    logic         w_bound_ok;
    logic         w_raw_zero;

    assign w_shift       = scale_shift(i_scale);
    assign w_scaled      = W'(i_raw) << w_shift;
    assign w_raw_zero    = (i_raw == '0);
    assign w_outstanding = w_scaled - r_cc;
    assign w_bound_ok    = (w_outstanding <= w_max);
    assign w_room        = r_cl - r_cc - i_req;

    always_comb begin
        w_max = M1;
        case (w_shift)
            3'd2:    w_max = M4;
            3'd4:    w_max = M16;
            default: w_max = M1;
        endcase
    end

    assign o_ok  = r_inf || (w_room <= HALF);
    assign o_inf = r_inf;

    // An update is only bound-checked when its scale matches the recorded one,
    // so using the incoming scale for w_max is equivalent in every accepted case.
    assign o_fcpe = (i_init && !w_raw_zero && !w_bound_ok) ||
                    (i_upd && (r_inf ? !w_raw_zero
                                     : ((w_shift != r_shift) || !w_bound_ok)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cl    <= '0;
            r_cc    <= '0;
            r_inf   <= 1'b0;
            r_shift <= 3'd0;
        end else if (i_clr) begin
            r_cl    <= '0;
            r_cc    <= '0;
            r_inf   <= 1'b0;
            r_shift <= 3'd0;
        end else begin
            if (i_cons && !r_inf)
                r_cc <= r_cc + i_req;
            if (i_init) begin
                r_shift <= w_shift;
                if (w_raw_zero)
                    r_inf <= 1'b1;
                else if (w_bound_ok)
                    r_cl <= w_scaled;
            end else if (i_upd && !r_inf && (w_shift == r_shift) && w_bound_ok) begin
                r_cl <= w_scaled;
            end
        end
    end

endmodule

// File: rtl/pcie_dll_fc_credit_gate.sv
// Transmit-side DLL flow-control credit gate: FC init FSM, per-type hdr/data credit slots,
// TLP grant and Flow Control Protocol Error reporting.
module pcie_dll_fc_credit_gate
    import pcie_dll_fc_credit_gate_pkg::*;
#(
    parameter int NUM_FC_TYPES    = pcie_dll_fc_credit_gate_pkg::NUM_FC_TYPES,
    parameter int HDR_FIELD_BITS  = pcie_dll_fc_credit_gate_pkg::HDR_FIELD_BITS,
    parameter int DATA_FIELD_BITS = pcie_dll_fc_credit_gate_pkg::DATA_FIELD_BITS,
    parameter int REQ_DATA_BITS   = pcie_dll_fc_credit_gate_pkg::REQ_DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_dl_up,
    input  logic                        i_fc_dllp_valid,
    input  logic [1:0]                  i_fc_dllp_kind,
    input  logic [1:0]                  i_fc_dllp_type,
    input  logic [1:0]                  i_fc_dllp_hdr_scale,
    input  logic [1:0]                  i_fc_dllp_data_scale,
    input  logic [7:0]                  i_fc_dllp_hdr_fc,
    input  logic [11:0]                 i_fc_dllp_data_fc,
    input  logic                        i_tlp_req_valid,
    input  logic [1:0]                  i_tlp_req_type,
    input  logic [REQ_DATA_BITS-1:0]    i_tlp_req_data,
    output logic                        o_tlp_req_ready,
    output logic                        o_fc_init_done,
    output logic [2*NUM_FC_TYPES-1:0]   o_fc_infinite,
    output logic                        o_fcpe
);

    localparam logic [2:0]                NT       = 3'(NUM_FC_TYPES);
    localparam logic [HDR_FIELD_BITS-1:0] HDR_ONE  = 1;

    fc_state_e                     r_state;
    fc_state_e                     w_state_nxt;
    logic [NUM_FC_TYPES-1:0]       r_rec;
    logic                          r_fcpe;

    fcp_hdr_t                      w_dllp;
    logic                          w_dllp_type_ok;
    logic                          w_is_init;
    logic                          w_is_upd;
    logic                          w_active;
    logic                          w_sel_ok;
    logic [NUM_FC_TYPES-1:0]       w_init_en;
    logic [NUM_FC_TYPES-1:0]       w_upd_en;
    logic [NUM_FC_TYPES-1:0]       w_cons;
    logic [NUM_FC_TYPES-1:0]       w_hdr_ok;
    logic [NUM_FC_TYPES-1:0]       w_data_ok;
    logic [2*NUM_FC_TYPES-1:0]     w_slot_fcpe;
    logic [DATA_FIELD_BITS-1:0]    w_req_data;

    assign w_dllp = '{kind:       dllp_fc_kind_e'(i_fc_dllp_kind),
                      fc_type:    i_fc_dllp_type,
                      hdr_scale:  i_fc_dllp_hdr_scale,
                      data_scale: i_fc_dllp_data_scale,
                      hdr_fc:     i_fc_dllp_hdr_fc,
                      data_fc:    i_fc_dllp_data_fc};

    assign w_dllp_type_ok = ({1'b0, w_dllp.fc_type} < NT);
    assign w_is_init = i_fc_dllp_valid && w_dllp_type_ok &&
                       ((w_dllp.kind == DLLP_INITFC1) || (w_dllp.kind == DLLP_INITFC2));
    assign w_is_upd  = i_fc_dllp_valid && w_dllp_type_ok && (w_dllp.kind == DLLP_UPDATEFC);
    assign w_active  = (r_state == FC_INIT2) || (r_state == FC_READY);
    assign w_req_data = DATA_FIELD_BITS'(i_tlp_req_data);

    always_comb begin
        w_sel_ok  = 1'b0;
        w_init_en = '0;
        w_upd_en  = '0;
        for (int t = 0; t < NUM_FC_TYPES; t++) begin
            if (i_tlp_req_type == 2'(t))
                w_sel_ok = w_hdr_ok[t] && w_data_ok[t];
            if (w_dllp.fc_type == 2'(t)) begin
                w_init_en[t] = (r_state == FC_INIT1) && w_is_init && !r_rec[t];
                w_upd_en[t]  = w_active && w_is_upd;
            end
        end
    end

    // Gated by i_dl_up directly so a request in flight as the link drops is never granted.
    assign o_tlp_req_ready = i_dl_up && w_active && w_sel_ok &&
                             ({1'b0, i_tlp_req_type} < NT);

    always_comb begin
        w_cons = '0;
        for (int t = 0; t < NUM_FC_TYPES; t++)
            w_cons[t] = i_tlp_req_valid && o_tlp_req_ready && (i_tlp_req_type == 2'(t));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FC_IDLE:  if (i_dl_up) w_state_nxt = FC_INIT1;
            FC_INIT1: if (&(r_rec | w_init_en)) w_state_nxt = FC_INIT2;
            FC_INIT2: if (w_is_upd || (w_is_init && w_dllp.kind == DLLP_INITFC2))
                          w_state_nxt = FC_READY;
            default:  w_state_nxt = r_state;
        endcase
        if (!i_dl_up)
            w_state_nxt = FC_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FC_IDLE;
            r_rec   <= '0;
            r_fcpe  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rec   <= i_dl_up ? (r_rec | w_init_en) : '0;
            r_fcpe  <= i_dl_up && (|w_slot_fcpe);
        end
    end

    assign o_fc_init_done = w_active;
    assign o_fcpe         = r_fcpe;

    for (genvar t = 0; t < NUM_FC_TYPES; t++) begin : g_type
        pcie_fc_credit_slot #(
            .W(HDR_FIELD_BITS), .RAW_W(HDR_FC_BITS),
            .MAX_1X(HDR_MAX_1X), .MAX_4X(HDR_MAX_4X), .MAX_16X(HDR_MAX_16X)
        ) u_hdr (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (!i_dl_up),
            .i_init  (w_init_en[t]),
            .i_upd   (w_upd_en[t]),
            .i_scale (w_dllp.hdr_scale),
            .i_raw   (w_dllp.hdr_fc),
            .i_cons  (w_cons[t]),
            .i_req   (HDR_ONE),
            .o_ok    (w_hdr_ok[t]),
            .o_inf   (o_fc_infinite[2*t]),
            .o_fcpe  (w_slot_fcpe[2*t])
        );

        pcie_fc_credit_slot #(
            .W(DATA_FIELD_BITS), .RAW_W(DATA_FC_BITS),
            .MAX_1X(DATA_MAX_1X), .MAX_4X(DATA_MAX_4X), .MAX_16X(DATA_MAX_16X)
        ) u_data (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (!i_dl_up),
            .i_init  (w_init_en[t]),
            .i_upd   (w_upd_en[t]),
            .i_scale (w_dllp.data_scale),
            .i_raw   (w_dllp.data_fc),
            .i_cons  (w_cons[t]),
            .i_req   (w_req_data),
            .o_ok    (w_data_ok[t]),
            .o_inf   (o_fc_infinite[2*t+1]),
            .o_fcpe  (w_slot_fcpe[2*t+1])
        );
    end

endmodule

// File: tb/tb_pcie_dll_fc_credit_gate.sv
// Directed bench for the FC credit gate: init/update, credit blocking, infinite credits,
// FCPE bound/scale errors, modulo wrap of the data counter and link-down clearing.
module tb_pcie_dll_fc_credit_gate;

    logic        clk;
    logic        rst_n;
    logic        dl_up;
    logic        dv;
    logic [1:0]  dk, dt, dhs, dds;
    logic [7:0]  dh;
    logic [11:0] dd;
    logic        rv;
    logic [1:0]  rt;
    logic [9:0]  rd;
    logic        ready, init_done, fcpe;
    logic [5:0]  inf;

    int checks = 0;
    int errors = 0;

    pcie_dll_fc_credit_gate dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_dl_up              (dl_up),
        .i_fc_dllp_valid      (dv),
        .i_fc_dllp_kind       (dk),
        .i_fc_dllp_type       (dt),
        .i_fc_dllp_hdr_scale  (dhs),
        .i_fc_dllp_data_scale (dds),
        .i_fc_dllp_hdr_fc     (dh),
        .i_fc_dllp_data_fc    (dd),
        .i_tlp_req_valid      (rv),
        .i_tlp_req_type       (rt),
        .i_tlp_req_data       (rd),
        .o_tlp_req_ready      (ready),
        .o_fc_init_done       (init_done),
        .o_fc_infinite        (inf),
        .o_fcpe               (fcpe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FC DLLP for one cycle; on return o_fcpe reflects this DLLP.
    task automatic send(input logic [1:0] kind, input logic [1:0] typ, input logic [1:0] hs,
                        input logic [1:0] ds, input logic [7:0] hfc, input logic [11:0] dfc);
        dv = 1'b1; dk = kind; dt = typ; dhs = hs; dds = ds; dh = hfc; dd = dfc;
        tick();
        dv = 1'b0;
    endtask

    task automatic req_once(input logic [1:0] typ, input logic [9:0] data, output logic rdy);
        rv = 1'b1; rt = typ; rd = data;
        #1 rdy = ready;
        tick();
        rv = 1'b0;
    endtask

    task automatic req_burst(input logic [1:0] typ, input logic [9:0] data, input int n,
                             inout int misses);
        logic r;
        for (int i = 0; i < n; i++) begin
            req_once(typ, data, r);
            if (r !== 1'b1) misses++;
        end
    endtask

    task automatic new_session();
        dl_up = 1'b0;
        tick();
        dl_up = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dl_up = 1'b1; dv = 0; dk = 0; dt = 0; dhs = 0; dds = 0; dh = 0; dd = 0;
        rv = 1'b1; rt = 2'd0; rd = 10'd0;
        #3;
        checks++;
        if ({ready, init_done, inf, fcpe} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {ready, init_done, inf, fcpe});
        end
        tick();
        rst_n = 1'b1; dl_up = 1'b0; rv = 1'b0;
        tick();
        tick();
        checks++;
        if ({ready, init_done, inf, fcpe} !== 9'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b want 0", {ready, init_done, inf, fcpe});
        end
    endtask

    task automatic test_init_update();
        logic r;
        new_session();
        send(2'd0, 2'd0, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd1, 2'b01, 2'b01, 8'd8, 12'd64);
        checks++;
        if (init_done !== 1'b0) begin
            errors++; $display("FAIL init_partial: got %b want 0", init_done);
        end
        send(2'd0, 2'd2, 2'b01, 2'b01, 8'd8, 12'd64);
        checks++;
        if (init_done !== 1'b1 || inf !== 6'b0) begin
            errors++; $display("FAIL init_done: got %b inf %b want 1 inf 0", init_done, inf);
        end
        send(2'd2, 2'd0, 2'b01, 2'b01, 8'd8, 12'd64);
        checks++;
        if (fcpe !== 1'b0 || init_done !== 1'b1) begin
            errors++; $display("FAIL update_ready: got fcpe %b done %b want 0 1", fcpe, init_done);
        end
        req_once(2'd0, 10'd64, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL p_grant64: got %b want 1", r); end
        req_once(2'd0, 10'd1, r);
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL p_block1: got %b want 0", r); end
        req_once(2'd1, 10'd64, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL np_independent: got %b want 1", r); end
        send(2'd2, 2'd0, 2'b01, 2'b01, 8'd8, 12'd65);
        checks++;
        if (fcpe !== 1'b0) begin errors++; $display("FAIL update65_fcpe: got %b want 0", fcpe); end
        req_once(2'd0, 10'd1, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL p_unblock: got %b want 1", r); end
        // Scale mismatch must flag and leave CL_data at 65 (CC now 65).
        send(2'd2, 2'd0, 2'b10, 2'b10, 8'd8, 12'd100);
        checks++;
        if (fcpe !== 1'b1) begin errors++; $display("FAIL scale_mismatch: got %b want 1", fcpe); end
        tick();
        checks++;
        if (fcpe !== 1'b0) begin errors++; $display("FAIL fcpe_one_cycle: got %b want 0", fcpe); end
        req_once(2'd0, 10'd1, r);
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL mismatch_cl_kept: got %b want 0", r); end
    endtask

    task automatic test_infinite();
        int misses = 0;
        new_session();
        send(2'd0, 2'd0, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd1, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd2, 2'b01, 2'b01, 8'd0, 12'd0);
        checks++;
        if (inf !== 6'b110000) begin errors++; $display("FAIL cpl_infinite: got %b want 110000", inf); end
        send(2'd2, 2'd2, 2'b01, 2'b01, 8'd0, 12'd0);
        checks++;
        if (fcpe !== 1'b0) begin errors++; $display("FAIL inf_zero_update: got %b want 0", fcpe); end
        req_burst(2'd2, 10'd256, 1000, misses);
        checks++;
        if (misses != 0) begin errors++; $display("FAIL cpl_1000: got %0d refused want 0", misses); end
        send(2'd2, 2'd2, 2'b01, 2'b01, 8'd5, 12'd0);
        checks++;
        if (fcpe !== 1'b1 || inf !== 6'b110000) begin
            errors++; $display("FAIL inf_nonzero_update: got fcpe %b inf %b want 1 110000", fcpe, inf);
        end
    endtask

    task automatic test_fcpe_bound();
        logic r;
        int misses = 0;
        new_session();
        send(2'd0, 2'd0, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd1, 2'b11, 2'b11, 8'd127, 12'd100);
        checks++;
        if (fcpe !== 1'b0) begin errors++; $display("FAIL np16x_init: got %b want 0", fcpe); end
        send(2'd0, 2'd2, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd2, 2'd1, 2'b11, 2'b11, 8'd128, 12'd100);
        checks++;
        if (fcpe !== 1'b1) begin errors++; $display("FAIL np_over2032: got %b want 1", fcpe); end
        tick();
        checks++;
        if (fcpe !== 1'b0) begin errors++; $display("FAIL np_fcpe_pulse: got %b want 0", fcpe); end
        req_burst(2'd1, 10'd0, 2032, misses);
        checks++;
        if (misses != 0) begin errors++; $display("FAIL np_2032: got %0d refused want 0", misses); end
        req_once(2'd1, 10'd0, r);
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL np_cl_kept: got %b want 0", r); end
        send(2'd2, 2'd0, 2'b01, 2'b01, 8'd127, 12'd64);
        checks++;
        if (fcpe !== 1'b0) begin errors++; $display("FAIL p_hdr127: got %b want 0", fcpe); end
        send(2'd2, 2'd0, 2'b01, 2'b01, 8'd128, 12'd64);
        checks++;
        if (fcpe !== 1'b1) begin errors++; $display("FAIL p_hdr128: got %b want 1", fcpe); end
    endtask

    // 16x data scaling can only express CL in multiples of 16, so the wrap point is CL=16.
    task automatic test_wrap();
        logic r;
        int misses = 0;
        int upd_err = 0;
        new_session();
        send(2'd0, 2'd0, 2'b01, 2'b11, 8'd0, 12'd2047);
        send(2'd0, 2'd1, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd2, 2'b01, 2'b01, 8'd8, 12'd64);
        req_burst(2'd0, 10'd256, 120, misses);
        send(2'd2, 2'd0, 2'b01, 2'b11, 8'd0, 12'd3967);
        if (fcpe !== 1'b0) upd_err++;
        req_burst(2'd0, 10'd256, 127, misses);
        send(2'd2, 2'd0, 2'b01, 2'b11, 8'd0, 12'd1);
        if (fcpe !== 1'b0) upd_err++;
        req_burst(2'd0, 10'd256, 8, misses);
        req_burst(2'd0, 10'd250, 1, misses);
        checks++;
        if (misses != 0 || upd_err != 0) begin
            errors++; $display("FAIL wrap_climb: got %0d refused %0d fcpe want 0 0", misses, upd_err);
        end
        req_once(2'd0, 10'd16, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL wrap_grant16: got %b want 1", r); end
        req_once(2'd0, 10'd6, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL wrap_grant6: got %b want 1", r); end
        req_once(2'd0, 10'd1, r);
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL wrap_block: got %b want 0", r); end
    endtask

    task automatic test_dl_down();
        logic r;
        rv = 1'b1; rt = 2'd1; rd = 10'd0;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL pre_drop_ready: got %b want 1", ready); end
        dl_up = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL drop_no_grant: got %b want 0", ready); end
        tick();
        checks++;
        if ({ready, init_done, inf, fcpe} !== 9'b0) begin
            errors++; $display("FAIL drop_cleared: got %b want 0", {ready, init_done, inf, fcpe});
        end
        rv = 1'b0;
        dl_up = 1'b1;
        tick();
        send(2'd2, 2'd1, 2'b01, 2'b01, 8'd8, 12'd64);
        req_once(2'd1, 10'd0, r);
        checks++;
        if (r !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL reup_needs_init: got rdy %b done %b want 0 0", r, init_done);
        end
        send(2'd0, 2'd0, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd1, 2'b01, 2'b01, 8'd8, 12'd64);
        send(2'd0, 2'd2, 2'b01, 2'b01, 8'd8, 12'd64);
        req_once(2'd1, 10'd0, r);
        checks++;
        if (r !== 1'b1 || init_done !== 1'b1) begin
            errors++; $display("FAIL reup_reinit: got rdy %b done %b want 1 1", r, init_done);
        end
    endtask

    initial begin
        test_reset();
        test_init_update();
        test_infinite();
        test_fcpe_bound();
        test_wrap();
        test_dl_down();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
